show_draw_scheduler: RTL

- Command sequencer in front of the rectangle/ASCII overlay drawer.
- Accepts draw commands (clear band, rectangle outline, one 8x16 character) through a valid/ready port and buffers them in a FIFO.
- Drives the drawer's command inputs with every field set on the same cycle, holds them for exactly as long as the drawer needs, then advances to the next command.
- Software/upstream logic posts commands and never tracks drawer timing.

---
 rtl/show_draw_scheduler.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/show_draw_scheduler.sv
// ---------------------------------------------------------------------------
// show_draw_scheduler
//   Command sequencer in front of the rectangle/ASCII overlay drawer.
//   Upstream posts draw commands (clear band, rectangle outline, one 8x16
//   character) through a valid/ready port. Commands are queued in a FIFO,
//   validated, and then presented to the drawer with every field updated on
//   a single edge. Each command is held for exactly as long as the drawer
//   needs, followed by a short idle guard so the drawer pipeline can drain.
//
// Ports
//   sys_clk, sys_rst        clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (transfer on valid & ready)
//   cmd_op                  0=clear band, 1=rect, 2=char, 3=reserved
//   cmd_ascii, cmd_color    character code / color
//   cmd_p0..cmd_p3          op0: ys,ye  op1: x1,y1,x2,y2  op2: x,y
//   o_ascii .. o_y2         registered drawer command fields
//   busy                    FIFO non-empty or sequencer not idle
//   done                    one-cycle pulse on the last guard cycle
//   err                     one-cycle pulse when a command is dropped
//   level                   FIFO occupancy
// ---------------------------------------------------------------------------
module show_draw_scheduler #(
  parameter int A_W        = 8,
  parameter int L_W        = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int GUARD      = 2
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [A_W-1:0]                cmd_ascii,
  input  logic [2:0]                    cmd_color,
  input  logic [L_W-1:0]                cmd_p0,
  input  logic [L_W-1:0]                cmd_p1,
  input  logic [L_W-1:0]                cmd_p2,
  input  logic [L_W-1:0]                cmd_p3,
  output logic [A_W-1:0]                o_ascii,
  output logic [2:0]                    o_color,
  output logic [L_W-1:0]                o_ys,
  output logic [L_W-1:0]                o_ye,
  output logic [L_W-1:0]                o_x,
  output logic [L_W-1:0]                o_y,
  output logic [L_W-1:0]                o_x1,
  output logic [L_W-1:0]                o_y1,
  output logic [L_W-1:0]                o_x2,
  output logic [L_W-1:0]                o_y2,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  // Longest hold is a full-height clear: (2^L_W + 1) * 256 cycles.
  localparam int CNT_W = L_W + 9;
  localparam int GW    = (GUARD > 1) ? $clog2(GUARD) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ALIGN, S_DRAW, S_GUARD} state_t;

  typedef struct packed {
    logic [1:0]     op;
    logic [A_W-1:0] ascii;
    logic [2:0]     color;
    logic [L_W-1:0] p0;
    logic [L_W-1:0] p1;
    logic [L_W-1:0] p2;
    logic [L_W-1:0] p3;
  } entry_t;

  typedef struct packed {
    logic [A_W-1:0] ascii;
    logic [2:0]     color;
    logic [L_W-1:0] ys;
    logic [L_W-1:0] ye;
    logic [L_W-1:0] x;
    logic [L_W-1:0] y;
    logic [L_W-1:0] x1;
    logic [L_W-1:0] y1;
    logic [L_W-1:0] x2;
    logic [L_W-1:0] y2;
  } drv_t;

  // ---------------- command FIFO ----------------
  entry_t          mem_q [FIFO_DEPTH];
  entry_t          cmd_in;
  entry_t          cur_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     level_q;
  logic            push, pop;

  state_t          state_q;
  logic [GW-1:0]   gcnt_q;

  assign cmd_in    = '{op: cmd_op, ascii: cmd_ascii, color: cmd_color,
                       p0: cmd_p0, p1: cmd_p1, p2: cmd_p2, p3: cmd_p3};
  assign cmd_ready = (level_q < (PW+1)'(FIFO_DEPTH));
  assign push      = cmd_valid & cmd_ready;
  // Pop from IDLE, or straight out of the last guard cycle (no idle bubble).
  assign pop       = (level_q != '0) &&
                     ((state_q == S_IDLE) || (state_q == S_GUARD && gcnt_q == '0));

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  // Registered read of the head entry.
  always_ff @(posedge sys_clk) begin
    if (pop) cur_q <= mem_q[rd_ptr_q];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // ---------------- decode of the popped entry ----------------
  drv_t            idle_drv, ld_drv_d, drv_q;
  logic            drop_d;
  logic [CNT_W-1:0] ld_cnt_d, cnt_q;
  logic [L_W-1:0]  dx, dy, dc;
  logic [L_W:0]    rect_sum, rows;
  logic [L_W+1:0]  rect_n;
  logic [CNT_W-1:0] clear_n;

  always_comb begin
    idle_drv       = '0;
    idle_drv.ascii = A_W'(32);

    dx       = cur_q.p2 - cur_q.p0;
    dy       = cur_q.p3 - cur_q.p1;
    dc       = cur_q.p1 - cur_q.p0;
    rect_sum = {1'b0, dx} + {1'b0, dy};
    rect_n   = {rect_sum, 1'b0} + (L_W+2)'(2);
    // One extra row so the clear scan re-aligns; 256 cycles per row.
    rows     = {1'b0, dc} + (L_W+1)'(2);
    clear_n  = {rows, 8'b0};

    drop_d   = 1'b0;
    ld_drv_d = '0;
    ld_cnt_d = '0;
    case (cur_q.op)
      2'd0: begin
        drop_d         = (cur_q.p1 < cur_q.p0);
        ld_drv_d.ascii = A_W'(0);
        ld_drv_d.ys    = cur_q.p0;
        ld_drv_d.ye    = cur_q.p1;
        ld_cnt_d       = clear_n - 1'b1;
      end
      2'd1: begin
        drop_d         = (cur_q.p2 < cur_q.p0) || (cur_q.p3 < cur_q.p1);
        ld_drv_d.ascii = A_W'(1);
        ld_drv_d.color = cur_q.color;
        ld_drv_d.x1    = cur_q.p0;
        ld_drv_d.y1    = cur_q.p1;
        ld_drv_d.x2    = cur_q.p2;
        ld_drv_d.y2    = cur_q.p3;
        ld_cnt_d       = CNT_W'(rect_n) - 1'b1;
      end
      2'd2: begin
        // Codes 0/1 are drawer opcodes; a space keeps the slot but draws nothing.
        ld_drv_d.ascii = (cur_q.ascii < A_W'(2)) ? A_W'(32) : cur_q.ascii;
        ld_drv_d.color = cur_q.color;
        ld_drv_d.x     = cur_q.p0;
        ld_drv_d.y     = cur_q.p1;
        ld_cnt_d       = CNT_W'(127);
      end
      default: drop_d = 1'b1;
    endcase
  end

  // ---------------- sequencer ----------------
  logic [6:0] phase_q;
  logic       done_q, err_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      drv_q   <= idle_drv;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      phase_q <= phase_q + 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          drv_q <= idle_drv;
          if (pop) state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (drop_d) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (cur_q.op == 2'd2 && phase_q != 7'd127) begin
            state_q <= S_ALIGN;
          end else begin
            // Characters reaching here already sit on the 127->0 edge.
            drv_q   <= ld_drv_d;
            cnt_q   <= ld_cnt_d;
            state_q <= S_DRAW;
          end
        end
        S_ALIGN: begin
          if (phase_q == 7'd127) begin
            drv_q   <= ld_drv_d;
            cnt_q   <= ld_cnt_d;
            state_q <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (cnt_q == '0) begin
            drv_q   <= idle_drv;
            gcnt_q  <= GW'(GUARD - 1);
            done_q  <= (GUARD == 1);
            state_q <= S_GUARD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_GUARD: begin
          if (gcnt_q != '0) begin
            gcnt_q <= gcnt_q - 1'b1;
            done_q <= (gcnt_q == GW'(1));
          end else begin
            state_q <= pop ? S_CHECK : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_ascii = drv_q.ascii;
  assign o_color = drv_q.color;
  assign o_ys    = drv_q.ys;
  assign o_ye    = drv_q.ye;
  assign o_x     = drv_q.x;
  assign o_y     = drv_q.y;
  assign o_x1    = drv_q.x1;
  assign o_y1    = drv_q.y1;
  assign o_x2    = drv_q.x2;
  assign o_y2    = drv_q.y2;
  assign busy    = (level_q != '0) || (state_q != S_IDLE);
  assign done    = done_q;
  assign err     = err_q;
  assign level   = level_q;

endmodule
